// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states and the
// encoded result held between done and the next accepted start.
package cmp_pkg;

    typedef enum logic {IDLE, COMPARE} cmp_state_t;

    typedef enum logic [1:0] {RES_NONE, RES_GT, RES_EQ, RES_LT} cmp_res_t;

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (da > db);
    assign eq = (da == db);
    assign lt = (da < db);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator with start/busy/done handshake.
// Signed operands are mapped to offset-binary at load so the datapath stays unsigned.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    localparam int NUM_DIGITS = WIDTH / DIGIT,
    localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_greater,
    output logic             a_equal,
    output logic             a_lesser,
    output logic [CNT_W-1:0] digits_used
);

    localparam logic [WIDTH-1:0] MSB_MASK  = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_DIGITS - 1);

    cmp_state_t       state_q, state_d;
    cmp_res_t         res_q, res_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dgt, deq, dlt;

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .da (sa_q[WIDTH-1 -: DIGIT]),
        .db (sb_q[WIDTH-1 -: DIGIT]),
        .gt (dgt),
        .eq (deq),
        .lt (dlt)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a ^ (signed_mode ? MSB_MASK : '0);
                    sb_d    = b ^ (signed_mode ? MSB_MASK : '0);
                    res_d   = RES_NONE;
                    cnt_d   = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // cnt_q holds digits already found equal; this cycle examines one more.
                if (dgt || dlt || (deq && cnt_q == LAST_IDX)) begin
                    res_d   = dgt ? RES_GT : (dlt ? RES_LT : RES_EQ);
                    cnt_d   = cnt_q + CNT_W'(1);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= RES_NONE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == COMPARE);
    assign done        = done_q;
    assign a_greater   = (res_q == RES_GT);
    assign a_equal     = (res_q == RES_EQ);
    assign a_lesser    = (res_q == RES_LT);
    assign digits_used = cnt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scenario tests plus randomized checking against an arithmetic reference compare.
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int ND    = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, a_greater, a_equal, a_lesser;
    logic [2:0]       digits_used;

    int n_checks = 0;
    int n_fail   = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .a_greater(a_greater),
        .a_equal(a_equal), .a_lesser(a_lesser), .digits_used(digits_used)
    );

    always #5 clk = ~clk;

    // res: 0 = greater, 1 = equal, 2 = lesser
    function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                  input logic ms, output int res, output int du);
        logic gt, lt;
        gt  = ms ? ($signed(ma) > $signed(mb)) : (ma > mb);
        lt  = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
        res = gt ? 0 : (lt ? 2 : 1);
        du  = ND;
        for (int d = 0; d < ND; d++) begin
            if (ma[WIDTH-1-DIGIT*d -: DIGIT] != mb[WIDTH-1-DIGIT*d -: DIGIT]) begin
                du = d + 1;
                break;
            end
        end
    endfunction

    function automatic int flags_code();
        return {29'd0, a_lesser, a_equal, a_greater};
    endfunction

    function automatic int res_code(input int res);
        return (res == 0) ? 1 : ((res == 1) ? 2 : 4);
    endfunction

    // Called at posedge+1; returns cycles from the accepting edge to done (50 = timeout).
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts, output int cyc);
        a = ta; b = tb; signed_mode = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, a_greater, a_equal, a_lesser, digits_used} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=0", {busy, done, a_greater, a_equal, a_lesser, digits_used});
        end
        rst_n = 1'b1;
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, a_greater, a_equal, a_lesser, digits_used} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_midop got=%b exp=0", {busy, done, a_greater, a_equal, a_lesser, digits_used});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_after got=%b exp=00", {busy, done});
        end
        run_op(16'h1234, 16'h1235, 1'b0, cyc);
        n_checks++;
        if (cyc != 4 || a_lesser !== 1'b1 || digits_used !== 3'd4) begin
            n_fail++;
            $display("FAIL reset_recover got cyc=%0d lt=%b du=%0d exp cyc=4 lt=1 du=4", cyc, a_lesser, digits_used);
        end
    endtask

    task automatic test_full_equal();
        int cyc;
        run_op(16'h1234, 16'h1234, 1'b0, cyc);
        n_checks++;
        if (cyc != 4 || flags_code() != 2 || digits_used !== 3'd4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_equal got cyc=%0d flags=%0d du=%0d busy=%b exp cyc=4 flags=2 du=4 busy=0",
                     cyc, flags_code(), digits_used, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || a_equal !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b eq=%b exp done=0 eq=1", done, a_equal);
        end
    endtask

    task automatic test_early_exit();
        int cyc;
        run_op(16'h8000, 16'h7FFF, 1'b0, cyc);
        n_checks++;
        if (cyc != 1 || flags_code() != 1 || digits_used !== 3'd1) begin
            n_fail++;
            $display("FAIL early_unsigned got cyc=%0d flags=%0d du=%0d exp cyc=1 flags=1 du=1", cyc, flags_code(), digits_used);
        end
        run_op(16'h8000, 16'h7FFF, 1'b1, cyc);
        n_checks++;
        if (cyc != 1 || flags_code() != 4 || digits_used !== 3'd1) begin
            n_fail++;
            $display("FAIL early_signed got cyc=%0d flags=%0d du=%0d exp cyc=1 flags=4 du=1", cyc, flags_code(), digits_used);
        end
    endtask

    task automatic test_mid_word();
        int cyc;
        run_op(16'h12A0, 16'h12B0, 1'b0, cyc);
        n_checks++;
        if (cyc != 3 || flags_code() != 4 || digits_used !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_word got cyc=%0d flags=%0d du=%0d exp cyc=3 flags=4 du=3", cyc, flags_code(), digits_used);
        end
        run_op(16'hFFFF, 16'hFFFE, 1'b1, cyc);
        n_checks++;
        if (cyc != 4 || flags_code() != 1 || digits_used !== 3'd4) begin
            n_fail++;
            $display("FAIL last_digit got cyc=%0d flags=%0d du=%0d exp cyc=4 flags=1 du=4", cyc, flags_code(), digits_used);
        end
    endtask

    task automatic test_handshake();
        int cyc;
        a = 16'h12A0; b = 16'h12B0; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (cyc < 50) begin
            a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            if (busy) begin
                n_checks++;
                if (flags_code() != 0) begin
                    n_fail++;
                    $display("FAIL flags_busy got=%0d exp=0", flags_code());
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        start = 1'b0;
        n_checks++;
        if (cyc != 3 || flags_code() != 4 || digits_used !== 3'd3) begin
            n_fail++;
            $display("FAIL handshake_ignore got cyc=%0d flags=%0d du=%0d exp cyc=3 flags=4 du=3", cyc, flags_code(), digits_used);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(16'h5555, 16'h5555, 1'b0, cyc);
        n_checks++;
        if (cyc != 4 || a_equal !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first got cyc=%0d eq=%b exp cyc=4 eq=1", cyc, a_equal);
        end
        a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || flags_code() != 0) begin
            n_fail++;
            $display("FAIL b2b_accept got busy=%b done=%b flags=%0d exp busy=1 done=0 flags=0", busy, done, flags_code());
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || flags_code() != 4 || digits_used !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_second got done=%b flags=%0d du=%0d exp done=1 flags=4 du=1", done, flags_code(), digits_used);
        end
    endtask

    task automatic test_random();
        int cyc, res, du, sel, errs_before;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        errs_before = n_fail;
        for (int i = 0; i < 10000; i++) begin
            ra  = 16'($urandom);
            rs  = 1'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) rb = 16'($urandom);
            else if (sel == 1) rb = ra;
            else begin
                rb = ra;
                rb[$urandom_range(0, WIDTH-1)] ^= 1'b1;
            end
            model(ra, rb, rs, res, du);
            run_op(ra, rb, rs, cyc);
            n_checks++;
            if (cyc != du || flags_code() != res_code(res) || int'(digits_used) != du || busy !== 1'b0) begin
                n_fail++;
                if (n_fail - errs_before < 10)
                    $display("FAIL random a=%h b=%h s=%b got cyc=%0d flags=%0d du=%0d busy=%b exp cyc=%0d flags=%0d du=%0d busy=0",
                             ra, rb, rs, cyc, flags_code(), digits_used, busy, du, res_code(res), du);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_equal();
        test_early_exit();
        test_mid_word();
        test_handshake();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
